// File: rtl/tt_sweep_checker_if.sv
// Signal bundle between the sweep checker and the combinational block it exercises.
// The checker owns the master side; a bench or harness attaches to the slave side.
interface tt_sweep_checker_if;
  logic       start;
  logic       f_in;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] first_err_idx;

  modport master (
    input  start, f_in,
    output A, B, C, D, busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    output start, f_in,
    input  A, B, C, D, busy, done, pass, err_count, first_err_idx
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// Exhaustive 4-input truth-table checker. Drives all 16 vectors, holds each for
// HOLD_CYCLES clocks and compares the response on the last cycle of every hold.
module tt_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [15:0] EXPECTED    = 16'hA5C3
) (
  input  logic                clk,
  input  logic                rst,
  tt_sweep_checker_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [4:0] err_q, err_d;
  logic [3:0] ferr_q, ferr_d;

  logic       cmp_edge;
  logic       mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      hold_q  <= 8'd0;
      err_q   <= 5'd0;
      ferr_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  // f_in only matters on the last cycle of a hold window.
  assign cmp_edge = (state_q == ST_RUN) && (hold_q == HOLD_LAST);
  assign mismatch = bus.f_in != EXPECTED[idx_q];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          idx_d   = 4'd0;
          hold_d  = 8'd0;
          err_d   = 5'd0;
          ferr_d  = 4'd0;
        end
      end
      ST_RUN: begin
        if (cmp_edge) begin
          hold_d = 8'd0;
          if (mismatch) begin
            err_d = err_q + 5'd1;
            if (err_q == 5'd0) ferr_d = idx_q;
          end
          // The last vector ends the sweep instead of wrapping the index.
          if (idx_q == 4'd15) state_d = ST_DONE;
          else                idx_d   = idx_q + 4'd1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stimulus is parked at zero whenever no sweep is in progress.
  logic [3:0] vec;
  assign vec = (state_q == ST_RUN) ? idx_q : 4'd0;

  assign bus.A             = vec[3];
  assign bus.B             = vec[2];
  assign bus.C             = vec[1];
  assign bus.D             = vec[0];
  assign bus.busy          = (state_q == ST_RUN);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.pass          = (err_q == 5'd0);
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = ferr_q;

endmodule
